supersonic: RTL and testbench

Ultrasonic ranging front-end (HC-SR04 style) answering the cutter controller's measurement requests. On a controller `trigger` request it drives a fixed-width trigger pulse to the sensor and acknowledges with `triggerSuc`. It then times the sensor echo and returns a quantised `distance` with a one-cycle `valid`. It sits between the top-level sensor pins and the controller.

---
 rtl/supersonic.sv | 162 ++++++++++++++++
 tb/tb_supersonic.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/supersonic.sv
// HC-SR04 style ranging front-end: issues the sensor trigger pulse on request,
// times the synchronised echo and reports the distance in quantised units.
module supersonic #(
  parameter int DisLen       = 16,
  parameter int TRIG_CYC     = 500,
  parameter int CYC_PER_UNIT = 2915,
  parameter int TIMEOUT_CYC  = 1500000,
  parameter int GAP_CYC      = 500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger,
  output logic            triggerSuc,
  output logic            valid,
  output logic [DisLen:0] distance,
  output logic            sr_trig,
  input  logic            sr_echo,
  output logic [2:0]      dbg_state_o
);

  // Handshake: trigger is a level request held by the controller until it sees
  // the one-cycle triggerSuc; valid is a one-cycle strobe with no back-pressure.

  localparam int MAX_A   = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_MAX = (MAX_A > TRIG_CYC) ? MAX_A : TRIG_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PRE_W   = $clog2(CYC_PER_UNIT + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CYC_PER_UNIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ECHO = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DisLen:0]  acc_q, acc_d;
  logic [DisLen:0]  dist_q, dist_d;
  logic             trig_q, trig_d;
  logic             suc_q, suc_d;
  logic             valid_q, valid_d;
  logic             echo_meta_q, echo_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    acc_d   = acc_q;
    dist_d  = dist_q;
    trig_d  = trig_q;
    suc_d   = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_TRIG;
          trig_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          trig_d  = 1'b0;
          suc_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (echo_s) begin
          state_d = S_ECHO;
          cnt_d   = '0;
          pre_d   = '0;
          acc_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_HOLD;
          dist_d  = '1;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ECHO: begin
        if (!echo_s) begin
          state_d = S_HOLD;
          dist_d  = acc_q;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_HOLD;
          dist_d  = '1;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Prescaler divides echo-high cycles into units; accumulator saturates.
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (acc_q != '1) acc_d = acc_q + 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        // A stuck-high echo keeps us here even after the gap has elapsed.
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!echo_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      acc_q       <= '0;
      dist_q      <= '0;
      trig_q      <= 1'b0;
      suc_q       <= 1'b0;
      valid_q     <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      acc_q       <= acc_d;
      dist_q      <= dist_d;
      trig_q      <= trig_d;
      suc_q       <= suc_d;
      valid_q     <= valid_d;
      echo_meta_q <= sr_echo;
      echo_s      <= echo_meta_q;
    end
  end

  assign triggerSuc  = suc_q;
  assign valid       = valid_q;
  assign distance    = dist_q;
  assign sr_trig     = trig_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_supersonic.sv
// Bench for supersonic: randomized measurements against a units/saturation
// reference model, plus timing checks on trigger pulse, gap, timeout and reset.
module tb_supersonic;

  localparam int TRIG_CYC = 4;
  localparam int CPU      = 10;
  localparam int TO       = 200;
  localparam int GAP      = 20;
  localparam int DL       = 16;
  localparam int DL3      = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trigger = 1'b0;
  logic sr_echo = 1'b0;
  logic trigger_suc, valid, sr_trig;
  logic [DL:0] distance;
  logic [2:0]  dbg_state;

  logic trigger3 = 1'b0;
  logic sr_echo3 = 1'b0;
  logic trigger_suc3, valid3, sr_trig3;
  logic [DL3:0] distance3;
  logic [2:0]   dbg_state3;

  int n_pass = 0;
  int n_checks = 0;
  int valid_cnt = 0;
  logic [DL:0] exp_q[$];
  logic [DL:0] all_ones = '1;

  always #5 clk = ~clk;

  supersonic #(.DisLen(DL), .TRIG_CYC(TRIG_CYC), .CYC_PER_UNIT(CPU),
               .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .triggerSuc(trigger_suc),
    .valid(valid), .distance(distance), .sr_trig(sr_trig), .sr_echo(sr_echo),
    .dbg_state_o(dbg_state)
  );

  supersonic #(.DisLen(DL3), .TRIG_CYC(TRIG_CYC), .CYC_PER_UNIT(CPU),
               .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut3 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger3), .triggerSuc(trigger_suc3),
    .valid(valid3), .distance(distance3), .sr_trig(sr_trig3), .sr_echo(sr_echo3),
    .dbg_state_o(dbg_state3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: event observed, required none", name);
  endtask

  // Echo high for n cycles: the first high cycle moves the FSM into ECHO and
  // is not timed, the rest are counted in whole units, capped at all-ones.
  function automatic int ref_units(input int high_cycles, input int msb);
    int units;
    int cap;
    units = (high_cycles - 1) / CPU;
    cap   = (1 << (msb + 1)) - 1;
    return (units > cap) ? cap : units;
  endfunction

  // which: 0 = sr_trig, 1 = triggerSuc, 2 = valid
  task automatic wait_sig(input int which, input int bound, input string name, output int cycles);
    bit done;
    done = 0;
    cycles = 0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if ((which == 0 && sr_trig === 1'b1) || (which == 1 && trigger_suc === 1'b1) ||
          (which == 2 && valid === 1'b1)) begin
        done = 1;
      end else if (cycles >= bound) begin
        n_checks++;
        $display("FAIL wait_%s: no event after %0d cycles, required within %0d", name, cycles, bound);
        done = 1;
      end
    end
  endtask

  // Monitor: scoreboard on valid, distance stability, trigger pulse shape.
  logic rst_seen = 1'b0;
  logic [DL:0] hold_dist = '0;
  logic prev_trig = 1'b0;
  int trig_len = 0;

  always @(posedge clk) rst_seen <= !rst_n;

  always @(negedge clk) begin
    if (rst_seen) begin
      hold_dist = '0;
      prev_trig = 1'b0;
      trig_len  = 0;
    end else begin
      if (valid === 1'b1) begin
        valid_cnt++;
        if (trigger_suc === 1'b1) fail_event("valid_with_triggerSuc");
        if (exp_q.size() == 0) fail_event("unexpected_valid");
        else check("distance", distance, exp_q.pop_front());
        hold_dist = distance;
      end else begin
        check("distance_hold", distance, hold_dist);
      end
      if (sr_trig === 1'b1) trig_len++;
      if (prev_trig && sr_trig === 1'b0) begin
        check("trig_pulse_len", trig_len, TRIG_CYC);
        check("triggerSuc_after_pulse", trigger_suc, 1);
        trig_len = 0;
      end else if (trigger_suc === 1'b1) begin
        fail_event("stray_triggerSuc");
      end
      prev_trig = sr_trig;
    end
  end

  task automatic start_meas(input bit drop_early);
    int c;
    trigger = 1'b1;
    wait_sig(0, 100, "sr_trig", c);
    if (drop_early) trigger = 1'b0;
    wait_sig(1, 100, "triggerSuc", c);
    trigger = 1'b0;
  endtask

  // hi_len == 0 means no echo at all: expect the wait-for-echo timeout.
  task automatic finish_meas(input int delay, input int hi_len);
    int c;
    if (hi_len > 0) begin
      exp_q.push_back(DL'(ref_units(hi_len, DL)));
      repeat (delay) @(negedge clk);
      sr_echo = 1'b1;
      repeat (hi_len) @(negedge clk);
      sr_echo = 1'b0;
      wait_sig(2, 50, "valid_echo", c);
    end else begin
      exp_q.push_back(all_ones);
      wait_sig(2, TO + 50, "valid_timeout", c);
      check("wait_timeout_latency", c, TO);
    end
  endtask

  initial begin
    int c;
    int len;
    int rises;
    int v_before;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int len;
    int rises;
    int v_before;
    bit done;

    repeat (3) @(negedge clk);
    check("rst_sr_trig", sr_trig, 0);
    check("rst_triggerSuc", trigger_suc, 0);
    check("rst_valid", valid, 0);
    check("rst_distance", distance, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_sr_trig", sr_trig, 0);
    check("idle_valid", valid, 0);

    // Directed: 105-cycle echo, then one-cycle valid and held distance.
    start_meas(0);
    finish_meas(7, 105);
    @(negedge clk);
    check("valid_one_cycle", valid, 0);
    check("distance_after_valid", distance, 10);

    // No echo: wait-state timeout.
    start_meas(0);
    finish_meas(0, 0);

    // Back-to-back: trigger re-raised one cycle after valid.
    start_meas(0);
    finish_meas(3, 47);
    @(negedge clk);
    trigger = 1'b1;
    wait_sig(0, 100, "b2b_sr_trig", c);
    check("b2b_trig_gap", c + 1, 21);
    start_meas(0);
    finish_meas(12, 66);

    // Stuck echo with trigger held high.
    trigger = 1'b1;
    wait_sig(1, 100, "stuck_triggerSuc", c);
    exp_q.push_back(all_ones);
    repeat (5) @(negedge clk);
    sr_echo = 1'b1;
    v_before = valid_cnt;
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sr_trig === 1'b1) rises++;
    end
    check("stuck_timeout_valid", valid_cnt - v_before, 1);
    check("no_trig_while_stuck", rises, 0);
    sr_echo = 1'b0;
    wait_sig(0, 100, "trig_after_stuck", c);
    check("trig_after_stuck_latency", c, 4);
    start_meas(0);
    finish_meas(0, 0);

    // Randomized measurements.
    for (int n = 0; n < 12; n++) begin
      start_meas(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        finish_meas(0, 0);
      end else begin
        do len = $urandom_range(1, 190); while (len % CPU == 0);
        finish_meas($urandom_range(1, 150), len);
      end
    end

    // Reset mid-ECHO after a nonzero result.
    start_meas(0);
    finish_meas(4, 83);
    start_meas(0);
    repeat (3) @(negedge clk);
    sr_echo = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sr_trig", sr_trig, 0);
    check("midrst_triggerSuc", trigger_suc, 0);
    check("midrst_valid", valid, 0);
    check("midrst_distance", distance, 0);
    check("midrst_state", dbg_state, 0);
    v_before = valid_cnt;
    repeat (10) @(negedge clk);
    sr_echo = 1'b0;
    repeat (TO + 50) @(negedge clk);
    check("no_valid_after_abort", valid_cnt - v_before, 0);
    start_meas(0);
    finish_meas(10, 57);

    // Narrow distance field saturates instead of wrapping.
    trigger3 = 1'b1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (trigger_suc3 === 1'b1) done = 1;
    end
    check("dut3_triggerSuc_seen", done, 1);
    trigger3 = 1'b0;
    repeat (5) @(negedge clk);
    sr_echo3 = 1'b1;
    repeat (180) @(negedge clk);
    sr_echo3 = 1'b0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (valid3 === 1'b1) done = 1;
    end
    check("dut3_valid_seen", done, 1);
    check("dut3_saturated_distance", distance3, ref_units(180, DL3));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
